// File: rtl/beta_dmem_responder.sv
// ---------------------------------------------------------------------------
// beta_dmem_responder
//
// Responder end of the Beta core data-memory port. Stores are posted and
// complete at the edge they are presented. Loads stall the core for
// 1+WAIT_CYCLES cycles and deliver their data in the following DONE cycle.
//
// Parameters:
//   ADDR_W      word-address width; array depth is 2**ADDR_W 32-bit words
//   WAIT_CYCLES extra load wait states (0..15)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   d_mem_addr   in   byte address; word index is d_mem_addr[ADDR_W+1:2]
//   d_mem_w_data in   store data
//   d_mem_we     in   store request
//   d_mem_oe     in   load request
//   d_mem_r_data out  load data, valid in the DONE cycle, held otherwise
//   d_mem_stall  out  core must hold its request while high
//   d_mem_err    out  one-cycle access-error pulse
//
// Optional feature (macro BETA_DMEM_ALIGN_CHECK_EN):
//   Misaligned or out-of-range requests pulse d_mem_err in their IDLE cycle;
//   such stores are dropped and such loads return 32'hDEADBEEF. Without the
//   macro d_mem_err is tied low and addresses wrap modulo the array depth.
// ---------------------------------------------------------------------------
module beta_dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_w_data,
  input  logic        d_mem_we,
  input  logic        d_mem_oe,
  output logic [31:0] d_mem_r_data,
  output logic        d_mem_stall,
  output logic        d_mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]  LP_WAIT   = 4'(WAIT_CYCLES);
  localparam logic [31:0] LP_BAD_RD = 32'hDEADBEEF;

  logic [31:0]       r_mem [0:(2**ADDR_W)-1];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_bad;
  logic [31:0]       r_rdata;
  logic              w_stall;
  logic              w_idle;
  logic              w_bad;
  logic              w_wr_en;
  logic              w_ld_start;
  logic [ADDR_W-1:0] w_idx;

  assign w_idx  = d_mem_addr[ADDR_W+1:2];
  assign w_idle = (r_state == S_IDLE);

`ifdef BETA_DMEM_ALIGN_CHECK_EN
  // A request is bad if it is not word aligned or has address bits above the array.
  assign w_bad     = (d_mem_addr[1:0] != 2'b00) || ((d_mem_addr >> (ADDR_W + 2)) != 32'd0);
  assign d_mem_err = !rst && w_idle && (d_mem_we || d_mem_oe) && w_bad;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{d_mem_addr[31:ADDR_W+2], d_mem_addr[1:0]};
  assign w_bad         = 1'b0;
  assign d_mem_err     = 1'b0;
`endif

  // Stores only land in IDLE; stores seen mid-load are protocol violations.
  assign w_wr_en    = !rst && w_idle && d_mem_we && !w_bad;
  assign w_ld_start = !rst && w_idle && d_mem_oe;

  // Stall is gated by reset so a request held through reset never stalls the core.
  assign d_mem_stall  = !rst && w_stall;
  assign d_mem_r_data = r_rdata;

  // Next-state, wait-counter and stall decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = d_mem_oe;
        if (d_mem_oe) begin
          if (LP_WAIT == 4'd0) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LP_WAIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (!d_mem_oe) begin
          // Core withdrew the load: abandon it without touching r_rdata.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, counter, latched request and load-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_bad   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_ld_start) begin
        r_idx <= w_idx;
        r_bad <= w_bad;
      end
      if (w_ld_start && (LP_WAIT == 4'd0)) begin
        // Zero wait states: read in the request cycle, forwarding a simultaneous store.
        if (w_bad) begin
          r_rdata <= LP_BAD_RD;
        end else if (w_wr_en) begin
          r_rdata <= d_mem_w_data;
        end else begin
          r_rdata <= r_mem[w_idx];
        end
      end else if ((r_state == S_WAIT) && (w_state_nxt == S_DONE)) begin
        r_rdata <= r_bad ? LP_BAD_RD : r_mem[r_idx];
      end
    end
  end

  // Word array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= d_mem_w_data;
    end
  end

endmodule

// File: tb/tb_beta_dmem_responder.sv
// ---------------------------------------------------------------------------
// Self-checking bench for beta_dmem_responder. Three instances with
// WAIT_CYCLES = 0, 1 and 3 are driven independently. A cycle-indexed model
// (load issued at cycle t stalls through t+W, delivers at t+W+1) checks
// stall, err and r_data of every instance on every falling edge; directed
// sequences add literal expectations for the key scenarios.
// ---------------------------------------------------------------------------
module tb_beta_dmem_responder;

`ifdef BETA_DMEM_ALIGN_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic        we      [3];
  logic        oe      [3];
  logic [31:0] rdata_o [3];
  logic        stall_o [3];
  logic        err_o   [3];

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    beta_dmem_responder #(
      .ADDR_W     (10),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .d_mem_addr  (addr[g]),
      .d_mem_w_data(wdata[g]),
      .d_mem_we    (we[g]),
      .d_mem_oe    (oe[g]),
      .d_mem_r_data(rdata_o[g]),
      .d_mem_stall (stall_o[g]),
      .d_mem_err   (err_o[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic logic [31:0] init_val(input int k, input int i);
    return (32'(k) << 28) ^ (32'(i) * 32'h0001_0003) ^ 32'h0BAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  int          cyc;
  bit          m_busy  [3];
  int          m_start [3];
  int          m_lidx  [3];
  bit          m_lbad  [3];
  logic [31:0] m_rd    [3];
  logic [31:0] m_mem   [3][1024];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      logic        e_stall;
      logic        e_err;
      bit          bad;
      int          idx;
      int          el;
      e_stall = 1'b0;
      e_err   = 1'b0;
      idx     = int'(addr[k][11:2]);
      bad     = FEAT && ((addr[k][1:0] != 2'b00) || (addr[k][31:12] != 20'd0));
      if (rst) begin
        m_busy[k] = 1'b0;
        m_rd[k]   = 32'd0;
      end else if (!m_busy[k]) begin
        e_stall = oe[k];
        e_err   = (we[k] || oe[k]) && bad;
        if (we[k] && !bad) m_mem[k][idx] = wdata[k];
        if (oe[k]) begin
          m_busy[k]  = 1'b1;
          m_start[k] = cyc;
          m_lidx[k]  = idx;
          m_lbad[k]  = bad;
        end
      end else begin
        el = cyc - m_start[k];
        if (el == wc(k) + 1) begin
          m_rd[k]   = m_lbad[k] ? 32'hDEADBEEF : m_mem[k][m_lidx[k]];
          m_busy[k] = 1'b0;
        end else begin
          e_stall = 1'b1;
          if (!oe[k]) m_busy[k] = 1'b0;
        end
      end
      chk($sformatf("model_stall[%0d]", k), {31'd0, stall_o[k]}, {31'd0, e_stall});
      chk($sformatf("model_err[%0d]", k), {31'd0, err_o[k]}, {31'd0, e_err});
      chk($sformatf("model_rdata[%0d]", k), rdata_o[k], m_rd[k]);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_load(input int k, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                         output int stalls, output int errs, output logic [31:0] data);
    @(posedge clk); #1;
    addr[k] = a; oe[k] = 1'b1; we[k] = wr; wdata[k] = wd;
    stalls = 0; errs = 0; data = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err_o[k]) errs++;
      if (stall_o[k]) stalls++;
      else begin
        data = rdata_o[k];
        break;
      end
      @(posedge clk); #1;
      we[k] = 1'b0;
    end
  endtask

  task automatic end_req(input int k);
    @(posedge clk); #1;
    oe[k] = 1'b0; we[k] = 1'b0;
  endtask

  task automatic do_store(input int k, input logic [31:0] a, input logic [31:0] d, output int errs);
    @(posedge clk); #1;
    addr[k] = a; wdata[k] = d; we[k] = 1'b1; oe[k] = 1'b0;
    @(negedge clk);
    chk("store_stall", {31'd0, stall_o[k]}, 32'd0);
    errs = int'(err_o[k]);
    @(posedge clk); #1;
    we[k] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          st;
    int          er;
    logic [31:0] d;
    logic [31:0] held;
    n_checks = 0; n_fail = 0; cyc = 0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'd0; wdata[k] = 32'd0; we[k] = 1'b0; oe[k] = 1'b0;
      m_busy[k] = 1'b0; m_rd[k] = 32'd0;
    end
    rst = 1'b1;
    oe[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_stall", {31'd0, stall_o[k]}, 32'd0);
      chk("reset_rdata", rdata_o[k], 32'd0);
      chk("reset_err", {31'd0, err_o[k]}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; oe[0] = 1'b0;

    // Fill every word of every instance with a known pattern.
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        addr[k] = 32'(i) << 2; wdata[k] = init_val(k, i); we[k] = 1'b1;
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) we[k] = 1'b0;

    // Store then load with one wait state.
    do_store(1, 32'h40, 32'h12345678, er);
    do_load(1, 32'h40, 1'b0, 32'd0, st, er, d);
    chk("w1_stall_cycles", 32'(st), 32'd2);
    chk("w1_load_data", d, 32'h12345678);
    end_req(1);

    // Latency sweep with back-to-back loads.
    do_load(0, 32'h40, 1'b0, 32'd0, st, er, d);
    chk("w0_stall_cycles", 32'(st), 32'd1);
    chk("w0_load_data", d, init_val(0, 16));
    do_load(0, 32'h44, 1'b0, 32'd0, st, er, d);
    chk("w0_b2b_stall", 32'(st), 32'd1);
    chk("w0_b2b_data", d, init_val(0, 17));
    end_req(0);
    do_load(2, 32'h40, 1'b0, 32'd0, st, er, d);
    chk("w3_stall_cycles", 32'(st), 32'd4);
    chk("w3_load_data", d, init_val(2, 16));
    do_load(2, 32'h44, 1'b0, 32'd0, st, er, d);
    chk("w3_b2b_stall", 32'(st), 32'd4);
    chk("w3_b2b_data", d, init_val(2, 17));
    end_req(2);

    // Simultaneous store and load returns the new word, for W=1 and W=0.
    do_load(1, 32'h80, 1'b1, 32'hA5A5A5A5, st, er, d);
    chk("simul_w1_data", d, 32'hA5A5A5A5);
    end_req(1);
    do_load(0, 32'h80, 1'b1, 32'h5A5A0F0F, st, er, d);
    chk("simul_w0_data", d, 32'h5A5A0F0F);
    end_req(0);

`ifdef BETA_DMEM_ALIGN_CHECK_EN
    do_load(1, 32'h42, 1'b0, 32'd0, st, er, d);
    chk("align_err_pulses", 32'(er), 32'd1);
    chk("align_load_data", d, 32'hDEADBEEF);
    end_req(1);
    do_store(1, 32'h1000, 32'h00000007, er);
    chk("range_store_err", 32'(er), 32'd1);
    do_load(1, 32'h0, 1'b0, 32'd0, st, er, d);
    chk("range_word0_kept", d, init_val(1, 0));
    chk("good_load_no_err", 32'(er), 32'd0);
    end_req(1);
`else
    do_store(1, 32'h1000, 32'h00000007, er);
    do_load(1, 32'h0, 1'b0, 32'd0, st, er, d);
    chk("wrap_load_data", d, 32'h00000007);
    chk("wrap_no_err", 32'(er), 32'd0);
    end_req(1);
`endif

    // Abort during WAIT keeps the previous load data.
    held = rdata_o[2];
    @(posedge clk); #1;
    addr[2] = 32'h100; oe[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    oe[2] = 1'b0;
    @(negedge clk);
    chk("abort_wait_stall", {31'd0, stall_o[2]}, 32'd1);
    @(negedge clk);
    chk("abort_idle_stall", {31'd0, stall_o[2]}, 32'd0);
    chk("abort_rdata_held", rdata_o[2], held);

    // Reset mid-WAIT, with a store held on another instance during reset.
    @(posedge clk); #1;
    addr[2] = 32'h200; oe[2] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    addr[0] = 32'h40; wdata[0] = 32'hFFFFFFFF; we[0] = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, stall_o[2]}, 32'd0);
    chk("rst_mid_rdata", rdata_o[2], 32'd0);
    chk("rst_store_stall", {31'd0, stall_o[0]}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; we[0] = 1'b0; oe[2] = 1'b0;
    do_load(0, 32'h40, 1'b0, 32'd0, st, er, d);
    chk("rst_no_write", d, init_val(0, 16));
    end_req(0);

    // Randomised traffic, including aborts, stray stores and short resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < 3; k++) begin
        logic [31:0] a;
        int          r;
        if (oe[k]) oe[k] = ($urandom_range(0, 9) != 0);
        else       oe[k] = ($urandom_range(0, 2) == 0);
        we[k] = ($urandom_range(0, 3) == 0);
        a = 32'($urandom_range(0, 15)) << 2;
        r = $urandom_range(0, 9);
        if (r == 0) a = a | (32'h0000_1000 << $urandom_range(0, 3));
        if (r == 1) a = a | 32'($urandom_range(1, 3));
        addr[k]  = a;
        wdata[k] = $urandom;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      oe[k] = 1'b0; we[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
